sram_ctrl: RTL and testbench
============================

// Module: sram_ctrl
// PURPOSE
// - Sequences every data-memory access from the MEM stage onto an external 16-bit asynchronous SRAM.
// - Each 32-bit word is transferred as two 16-bit halves: low half first, then high half.
// - Drives `ready` low while an access is in flight. The top level ties freeze = hazard | ~ready,
//   so the whole pipeline stalls until the access completes.
// - Sits between EXE_Stage_Reg outputs (mem_read, mem_write, alu_res, val_rm) and the MEM_Stage_Reg data input.
// PARAMETERS
// - BASE_ADDR    1024  byte address of data-memory word 0; subtracted before mapping
// - SRAM_ADDR_W  18    SRAM address width (16-bit locations)
// - WAIT_CYCLES  5     cycles each half-access is held on the SRAM bus; must be >= 2
// PORTS
// - clk          in   1            pipeline clock; single clock domain
// - rst          in   1            synchronous, active-high reset
// - wr_en        in   1            write request; held stable until ready=1
// - rd_en        in   1            read request; held stable until ready=1
// - address      in   32           byte address (ALU result)
// - write_data   in   32           store data (Val_Rm)
// - read_data    out  32           registered load data
// - ready        out  1            1 = no access pending or access completing this cycle
// - sram_addr    out  SRAM_ADDR_W  SRAM address
// - sram_we_n    out  1            SRAM write enable, active low
// - sram_dq_out  out  16           data driven to SRAM
// - sram_dq_oe   out  1            1 = drive sram_dq_out onto the bus (pad tristate sits at top level)
// - sram_dq_in   in   16           data returned by SRAM
// BEHAVIOUR
// - Reset (synchronous, any state): state=IDLE, counter=0, read_data=0, sram_addr=0, sram_we_n=1,
//   sram_dq_oe=0, sram_dq_out=0. `ready` is 1 once in IDLE with no request.
// - Address map: idx = (address - BASE_ADDR) >> 2, truncated to SRAM_ADDR_W-1 bits.
//   Low half goes to {idx,1'b0}, high half to {idx,1'b1}. No range check.
// - FSM states: IDLE, LOW, HIGH, DONE.
//   IDLE -> LOW when rd_en|wr_en. Counter cleared on entry.
//   LOW  -> HIGH after WAIT_CYCLES cycles in LOW, i.e. when counter==WAIT_CYCLES-1.
//   HIGH -> DONE after WAIT_CYCLES cycles in HIGH.
//   DONE -> IDLE unconditionally, after exactly 1 cycle.
// - ready (combinational): 1 in DONE. 1 in IDLE when rd_en=wr_en=0. 0 otherwise.
//   The IDLE cycle that sees a request already drives ready=0.
// - Latency: request seen in IDLE at cycle 0, then LOW in cycles 1..W, HIGH in W+1..2W, DONE at 2W+1
//   with ready=1. Total 2W+2 cycles per access, back-to-back included, because every access passes through IDLE.
// - Write, per phase:
//   - sram_dq_oe=1 for the whole phase.
//   - sram_dq_out = write_data[15:0] in LOW, write_data[31:16] in HIGH.
//   - sram_we_n=0 for phase cycles 1..W-1 and 1 in the last cycle, so address and data hold past the WE rising edge.
// - Read, per phase:
//   - sram_we_n=1, sram_dq_oe=0.
//   - sram_dq_in is captured in the last cycle of LOW into read_data[15:0] and of HIGH into read_data[31:16].
//   - read_data holds its value otherwise, including across writes.
// - Stability: address, write_data and request type are latched at IDLE->LOW. Later input changes
//   (flush, deassertion) do not affect an access in flight; it always runs to DONE.
// - Simultaneous rd_en & wr_en: treated as a write. read_data is unchanged.
// - Reset mid-access: the FSM aborts to IDLE on the next edge with sram_we_n=1.
//   A partially written half may remain in the SRAM; that is accepted.
// - Outside LOW and HIGH: sram_we_n=1, sram_dq_oe=0, sram_addr holds its last value.
// STRUCTURE
// - Shared include arm_defines.vh: state encodings (SRAM_IDLE, SRAM_LOW, SRAM_HIGH, SRAM_DONE,
//   2 bits) and the BASE_ADDR default.
// - Single module. It contains the 2-bit state register, a $clog2(WAIT_CYCLES)-bit phase counter,
//   latched request registers and the read_data register.
// - No sub-module. The bench supplies a behavioural sram_model: 2^SRAM_ADDR_W x 16 array,
//   write on sram_we_n rising edge, combinational read.
// TESTING (W=5 unless stated)
// - Idle: rd_en=wr_en=0 for 10 cycles -> ready=1, sram_we_n=1, sram_dq_oe=0 throughout.
// - Write: wr_en=1, address=1024, write_data=32'hDEADBEEF -> model[0]=16'hBEEF, model[1]=16'hDEAD,
//   ready=0 for cycles 0..10 and ready=1 at cycle 11 only.
// - Read: rd_en=1, address=1024 after the write -> read_data=32'hDEADBEEF at DONE,
//   with sram_we_n=1 and sram_dq_oe=0 for the whole access.
// - Back-to-back: write 32'h12345678 to 1028, then read 1028 held on the next cycle -> model[2]=16'h5678,
//   model[3]=16'h1234; read completes 12 cycles after write DONE with read_data=32'h12345678.
// - Reset mid-access: assert rst at cycle 3 of a write -> next cycle state IDLE, sram_we_n=1,
//   sram_dq_oe=0, read_data=0; model[1] untouched.
// - Conflict, W=2: rd_en=wr_en=1, address=1032, write_data=32'hA5A5_0F0F -> write performed
//   (model[4]=16'h0F0F, model[5]=16'hA5A5), read_data unchanged, ready at cycle 5.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and helpers for the 16-bit asynchronous SRAM data-memory controller.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLow  = 2'd1,
      StHigh = 2'd2,
      StDone = 2'd3
   } sram_state_e;

   localparam int unsigned DefaultBaseAddr = 1024;

   // Word offset of a byte address relative to the data-memory base.
   function automatic logic [31:0] word_offset(input logic [31:0] addr, input logic [31:0] base);
      return (addr - base) >> 2;
   endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Splits each 32-bit MEM-stage access into two timed 16-bit SRAM cycles (low half, then high half)
// and holds ready low until the access completes.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned BASE_ADDR   = DefaultBaseAddr,
   parameter int unsigned SRAM_ADDR_W = 18,
   parameter int unsigned WAIT_CYCLES = 5
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic                   rd_en,
   input  logic [31:0]            address,
   input  logic [31:0]            write_data,
   output logic [31:0]            read_data,
   output logic                   ready,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic                   sram_we_n,
   output logic [15:0]            sram_dq_out,
   output logic                   sram_dq_oe,
   input  logic [15:0]            sram_dq_in
);

   localparam int unsigned CntW = $clog2(WAIT_CYCLES);
   localparam int unsigned IdxW = SRAM_ADDR_W - 1;
   localparam logic [CntW-1:0] CntLast    = CntW'(WAIT_CYCLES - 1);
   localparam logic [CntW-1:0] CntPreLast = CntW'(WAIT_CYCLES - 2);

   sram_state_e     state_q;
   logic [CntW-1:0] cnt_q;
   logic            is_write_q;
   logic [IdxW-1:0] idx_q;
   logic [31:0]     wdata_q;
   logic [IdxW-1:0] req_idx;

   assign req_idx = IdxW'(word_offset(address, BASE_ADDR));
   assign ready   = (state_q == StDone) || ((state_q == StIdle) && !rd_en && !wr_en);

   // SRAM pins are registered one cycle ahead: each transition sets up what the next cycle drives.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         is_write_q  <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         read_data   <= '0;
         sram_addr   <= '0;
         sram_we_n   <= 1'b1;
         sram_dq_oe  <= 1'b0;
         sram_dq_out <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (rd_en || wr_en) begin
                  state_q     <= StLow;
                  cnt_q       <= '0;
                  is_write_q  <= wr_en;
                  idx_q       <= req_idx;
                  wdata_q     <= write_data;
                  sram_addr   <= {req_idx, 1'b0};
                  sram_we_n   <= ~wr_en;
                  sram_dq_oe  <= wr_en;
                  sram_dq_out <= write_data[15:0];
               end
            end
            StLow: begin
               if (cnt_q == CntLast) begin
                  state_q     <= StHigh;
                  cnt_q       <= '0;
                  if (!is_write_q) read_data[15:0] <= sram_dq_in;
                  sram_addr   <= {idx_q, 1'b1};
                  sram_we_n   <= ~is_write_q;
                  sram_dq_out <= wdata_q[31:16];
               end else begin
                  cnt_q     <= cnt_q + CntW'(1);
                  // WE rises one cycle early so address and data hold past it.
                  sram_we_n <= ~is_write_q | (cnt_q == CntPreLast);
               end
            end
            StHigh: begin
               if (cnt_q == CntLast) begin
                  state_q    <= StDone;
                  cnt_q      <= '0;
                  if (!is_write_q) read_data[31:16] <= sram_dq_in;
                  sram_we_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
               end else begin
                  cnt_q     <= cnt_q + CntW'(1);
                  sram_we_n <= ~is_write_q | (cnt_q == CntPreLast);
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: vector table, hand-written corner cases and a randomized
// phase against a word-level reference memory.
module tb_sram_ctrl;

   localparam int W  = 5;
   localparam int W2 = 2;

   logic        clk = 1'b0;
   logic        rst;
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_fail = 0;

   // W=5 instance
   logic        rd_en, wr_en;
   logic [31:0] address, write_data, read_data;
   logic        ready, sram_we_n, sram_dq_oe;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic [15:0] mem5 [0:(1<<18)-1];

   // W=2 instance
   logic        rd2, wr2;
   logic [31:0] addr2, wd2, rdata2;
   logic        ready2, we2, oe2;
   logic [9:0]  sa2;
   logic [15:0] dqo2, dqi2;
   logic [15:0] mem2 [0:(1<<10)-1];

   sram_ctrl #(.BASE_ADDR(1024), .SRAM_ADDR_W(18), .WAIT_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
      .sram_we_n(sram_we_n), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in)
   );

   sram_ctrl #(.BASE_ADDR(1024), .SRAM_ADDR_W(10), .WAIT_CYCLES(W2)) dut2 (
      .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2), .address(addr2),
      .write_data(wd2), .read_data(rdata2), .ready(ready2), .sram_addr(sa2),
      .sram_we_n(we2), .sram_dq_out(dqo2), .sram_dq_oe(oe2), .sram_dq_in(dqi2)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural SRAMs: write on WE rising edge, combinational read.
   always @(posedge sram_we_n) if (sram_dq_oe) mem5[sram_addr] <= sram_dq_out;
   always @(posedge we2) if (oe2) mem2[sa2] <= dqo2;
   assign sram_dq_in = mem5[sram_addr];
   assign dqi2       = mem2[sa2];

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_we_lo;
      int          exp_oe_hi;
   } vec_t;

   vec_t        vecs [4];
   int          lat, we_lo, oe_hi, dcyc, dcyc_wr;
   logic [31:0] rdd;
   logic [31:0] ref_w [8];
   bit          valid [8];
   logic [31:0] ref_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Called just after a posedge; returns just after the posedge that leaves DONE.
   task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input bit scramble, output int l, output int wl, output int oh,
                         output int dc, output logic [31:0] rd_at_done);
      bit done = 0;
      rd_en = r; wr_en = w; address = a; write_data = d;
      l = 0; wl = 0; oh = 0; dc = 0; rd_at_done = 'x;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (!sram_we_n) wl++;
         if (sram_dq_oe) oh++;
         if (ready) begin
            done = 1; dc = cyc; rd_at_done = read_data;
            break;
         end
         l++;
         if (scramble && i >= 1) begin
            address = $urandom; write_data = $urandom;
            rd_en = 1'($urandom_range(0, 1)); wr_en = 1'($urandom_range(0, 1));
         end
      end
      if (!done) begin
         n_cmp++; n_fail++;
         $display("FAIL timeout: ready still 0 after %0d cycles, required 1 within 64", l);
      end
      @(posedge clk); #1;
      rd_en = 0; wr_en = 0;
   endtask

   task automatic access2(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, output int l, output logic [31:0] rd_at_done);
      bit done = 0;
      rd2 = r; wr2 = w; addr2 = a; wd2 = d;
      l = 0; rd_at_done = 'x;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (ready2) begin
            done = 1; rd_at_done = rdata2;
            break;
         end
         l++;
      end
      if (!done) begin
         n_cmp++; n_fail++;
         $display("FAIL timeout2: ready still 0 after %0d cycles, required 1 within 64", l);
      end
      @(posedge clk); #1;
      rd2 = 0; wr2 = 0;
   endtask

   initial begin
      vecs[0] = '{1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 32'h0,        8, 10};
      vecs[1] = '{1'b1, 1'b0, 32'd1024, 32'h0,        32'hDEADBEEF, 0, 0};
      vecs[2] = '{1'b0, 1'b1, 32'd1028, 32'h12345678, 32'hDEADBEEF, 8, 10};
      vecs[3] = '{1'b1, 1'b0, 32'd1028, 32'h0,        32'h12345678, 0, 0};

      rd_en = 0; wr_en = 0; address = 0; write_data = 0;
      rd2 = 0; wr2 = 0; addr2 = 0; wd2 = 0;
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      // Reset state and idle behaviour
      @(negedge clk);
      check("reset_read_data", read_data, 32'h0);
      check("reset_sram_addr", 32'(sram_addr), 32'h0);
      check("reset_dq_out", 32'(sram_dq_out), 32'h0);
      for (int i = 0; i < 10; i++) begin
         check("idle_flags", {29'h0, ready, sram_we_n, sram_dq_oe}, 32'b110);
         @(negedge clk);
      end
      @(posedge clk); #1;

      // Table: write/read 1024, then back-to-back write/read on 1028
      for (int i = 0; i < 4; i++) begin
         access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0,
                lat, we_lo, oe_hi, dcyc, rdd);
         check("vec_latency", 32'(lat), 32'(2 * W + 1));
         check("vec_we_low_cycles", 32'(we_lo), 32'(vecs[i].exp_we_lo));
         check("vec_oe_cycles", 32'(oe_hi), 32'(vecs[i].exp_oe_hi));
         check("vec_read_data", rdd, vecs[i].exp_rdata);
         if (i == 2) dcyc_wr = dcyc;
         if (i == 3) check("b2b_read_gap", 32'(dcyc - dcyc_wr), 32'd12);
      end
      check("mem0", 32'(mem5[0]), 32'hBEEF);
      check("mem1", 32'(mem5[1]), 32'hDEAD);
      check("mem2", 32'(mem5[2]), 32'h5678);
      check("mem3", 32'(mem5[3]), 32'h1234);

      // Reset at cycle 3 of a write to word 0
      wr_en = 1; address = 32'd1024; write_data = 32'h0BADF00D;
      repeat (3) begin
         @(posedge clk); #1;
      end
      rst = 1; wr_en = 0;
      @(posedge clk); #1;
      rst = 0;
      @(negedge clk);
      check("midrst_flags", {29'h0, ready, sram_we_n, sram_dq_oe}, 32'b110);
      check("midrst_read_data", read_data, 32'h0);
      check("midrst_mem1", 32'(mem5[1]), 32'hDEAD);
      @(posedge clk); #1;

      // Randomized phase against a word-level reference memory
      for (int k = 0; k < 8; k++) valid[k] = 0;
      ref_w[1] = 32'h12345678; valid[1] = 1;
      ref_rd = 32'h0;
      for (int it = 0; it < 150; it++) begin
         int          op, wi;
         logic        r, wv;
         logic [31:0] d;
         op = $urandom_range(0, 3);
         wi = $urandom_range(0, 7);
         d  = $urandom;
         r  = (op != 1);
         wv = (op == 1) || (op == 2);
         if (!wv && !valid[wi]) begin
            wv = 1; r = 0;
         end
         access(r, wv, 32'(1024 + 4 * wi), d, 1'b1, lat, we_lo, oe_hi, dcyc, rdd);
         if (wv) begin
            ref_w[wi] = d; valid[wi] = 1;
            check("rand_mem_lo", 32'(mem5[2 * wi]), 32'(d[15:0]));
            check("rand_mem_hi", 32'(mem5[2 * wi + 1]), 32'(d[31:16]));
         end else begin
            ref_rd = ref_w[wi];
         end
         check("rand_read_data", rdd, ref_rd);
         check("rand_latency", 32'(lat), 32'(2 * W + 1));
         check("rand_we_low_cycles", 32'(we_lo), wv ? 32'(2 * (W - 1)) : 32'h0);
         check("rand_oe_cycles", 32'(oe_hi), wv ? 32'(2 * W) : 32'h0);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
      end

      // W=2: simultaneous rd_en & wr_en is a write and leaves read_data alone
      access2(1'b0, 1'b1, 32'd1024, 32'hC3C33C3C, lat, rdd);
      access2(1'b1, 1'b0, 32'd1024, 32'h0, lat, rdd);
      check("w2_read_data", rdd, 32'hC3C33C3C);
      access2(1'b1, 1'b1, 32'd1032, 32'hA5A50F0F, lat, rdd);
      check("w2_conflict_latency", 32'(lat), 32'd5);
      check("w2_conflict_read_data", rdd, 32'hC3C33C3C);
      check("w2_mem4", 32'(mem2[4]), 32'h0F0F);
      check("w2_mem5", 32'(mem2[5]), 32'hA5A5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
